// File: rtl/instruction_cache.sv
`default_nettype none
// ============================================================================
// Module      : instruction_cache
// Description : 8-line direct-mapped read-only instruction cache with
//               128-bit (4-word) blocks. Hits return in the same cycle;
//               misses stall the CPU while a whole block is fetched.
// Options     : define ICACHE_PERF_COUNTERS_EN to add HIT_COUNT/MISS_COUNT.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_cache (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  CPU_ADDRESS,
  input  logic         CPU_READ,
  output logic [31:0]  CPU_INSTRUCTION,
  output logic         CPU_BUSYWAIT,
  output logic         MEM_READ,
  output logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
`ifdef ICACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
`endif
);

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_MEM_READ = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [27:0]  mem_addr_q, mem_addr_d;
  logic [7:0]   valid_q, valid_d;
  logic [24:0]  tag_q  [8];
  logic [127:0] data_q [8];

  // Address fields of the current fetch
  logic [24:0]  cpu_tag;
  logic [2:0]   cpu_index;
  logic [1:0]   cpu_offset;
  logic [2:0]   fill_index;
  logic         unused_addr_bits;

  logic         hit;
  logic [31:0]  hit_word;
  logic         fill_en;

  assign cpu_tag          = CPU_ADDRESS[31:7];
  assign cpu_index        = CPU_ADDRESS[6:4];
  assign cpu_offset       = CPU_ADDRESS[3:2];
  assign unused_addr_bits = ^CPU_ADDRESS[1:0];
  // The line being filled always comes from the latched block address,
  // so a PC change during the fill cannot redirect it.
  assign fill_index       = mem_addr_q[2:0];

  // Combinational lookup and word select for the current fetch
  always_comb begin
    hit = CPU_READ && valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);
    case (cpu_offset)
      2'd0:    hit_word = data_q[cpu_index][31:0];
      2'd1:    hit_word = data_q[cpu_index][63:32];
      2'd2:    hit_word = data_q[cpu_index][95:64];
      default: hit_word = data_q[cpu_index][127:96];
    endcase
  end

  // Next-state, fill control and CPU/memory-side outputs
  always_comb begin
    state_d         = state_q;
    mem_addr_d      = mem_addr_q;
    valid_d         = valid_q;
    fill_en         = 1'b0;
    CPU_BUSYWAIT    = 1'b0;
    CPU_INSTRUCTION = 32'h0;
    MEM_READ        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CPU_READ && !hit) begin
          CPU_BUSYWAIT = 1'b1;
          state_d      = S_MEM_READ;
          mem_addr_d   = CPU_ADDRESS[31:4];
        end else if (hit) begin
          CPU_INSTRUCTION = hit_word;
        end
      end
      S_MEM_READ: begin
        CPU_BUSYWAIT = 1'b1;
        MEM_READ     = 1'b1;
        if (!MEM_BUSYWAIT) begin
          fill_en             = 1'b1;
          valid_d[fill_index] = 1'b1;
          state_d             = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign MEM_ADDRESS = mem_addr_q;

  // Control state: asynchronous reset invalidates every line and aborts a fill
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      mem_addr_q <= 28'h0;
      valid_q    <= 8'h0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
    end
  end

  // Tag/data storage needs no reset: contents are qualified by valid_q
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[fill_index]  <= mem_addr_q[27:3];
      data_q[fill_index] <= MEM_READDATA;
    end
  end

`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Hits count per IDLE hit edge, misses per IDLE->MEM_READ transition
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == S_IDLE) begin
      if (hit)           hit_count_d  = hit_count_q + 32'd1;
      else if (CPU_READ) miss_count_d = miss_count_q + 32'd1;
    end
  end

  // Performance counter registers, wrapping naturally at 2^32
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule
`default_nettype wire
